// File: rtl/score_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_manager_pkg
// Description : Shared types and helpers for the Needleman-Wunsch score
//               matrix store: score width, fetch phase encoding and the
//               row-major linear address function.
// Revision    : 1.0 - initial release
// ============================================================================
package score_manager_pkg;

  localparam int c_SCORE_W = 9;

  // Neighbour fetch phase; also drives the count_3 output directly.
  typedef enum logic [1:0] {
    DIAG = 2'd0,
    UP   = 2'd1,
    LEFT = 2'd2
  } phase_t;

  // Row-major linear address of cell (row, col) in an (n+1)x(n+1) matrix.
  function automatic int lin_addr(input int row, input int col, input int n);
    return row * (n + 1) + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : score_manager_if
// Description : Command / result bundle between the Needleman-Wunsch
//               controller (master) and the score matrix store (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface score_manager_if #(
  parameter int N           = 5,
  parameter int BitAddr     = $clog2(N),
  parameter int addr_lenght = $clog2((N + 1) * (N + 1) - 1)
);
  import score_manager_pkg::*;

  logic                   en_init;
  logic                   en_ins;
  logic                   en_read;
  logic                   we;
  logic [BitAddr:0]       i;
  logic [BitAddr:0]       j;
  logic [BitAddr:0]       addr_init;
  logic [c_SCORE_W-1:0]   max;
  logic [c_SCORE_W-1:0]   data_init;
  logic [1:0]             count_3;
  logic [addr_lenght:0]   addr_r;
  logic [c_SCORE_W-1:0]   diag;
  logic [c_SCORE_W-1:0]   up;
  logic [c_SCORE_W-1:0]   left;
  logic [c_SCORE_W-1:0]   score;
  logic                   ready;
  logic                   signal;

  modport master (
    output en_init, en_ins, en_read, we, i, j, addr_init, max, data_init,
    input  count_3, addr_r, diag, up, left, score, ready, signal
  );

  modport slave (
    input  en_init, en_ins, en_read, we, i, j, addr_init, max, data_init,
    output count_3, addr_r, diag, up, left, score, ready, signal
  );

endinterface
`default_nettype wire

// File: rtl/score_ram.sv
`default_nettype none
// ============================================================================
// Module      : score_ram
// Description : Register-array storage with two write ports and two
//               asynchronous read ports. Port 1 wins on a same-address
//               write collision. Addresses beyond DEPTH are dropped on
//               write and read back as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module score_ram #(
  parameter int DEPTH = 36,
  parameter int AW    = 7,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we0,
  input  logic [AW-1:0] i_wa0,
  input  logic [DW-1:0] i_wd0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_wa1,
  input  logic [DW-1:0] i_wd1,
  input  logic [AW-1:0] i_ra0,
  output logic [DW-1:0] o_rd0,
  input  logic [AW-1:0] i_ra1,
  output logic [DW-1:0] o_rd1
);

  localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic          w_wr0_ok;
  logic          w_wr1_ok;

  assign w_wr0_ok = i_we0 && (int'(i_wa0) < DEPTH);
  assign w_wr1_ok = i_we1 && (int'(i_wa1) < DEPTH);

  // Cell storage: both write ports update on the same edge, port 1 last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) r_mem[a] <= '0;
    end else begin
      if (w_wr0_ok) r_mem[i_wa0[c_IW-1:0]] <= i_wd0;
      if (w_wr1_ok) r_mem[i_wa1[c_IW-1:0]] <= i_wd1;
    end
  end

  assign o_rd0 = (int'(i_ra0) < DEPTH) ? r_mem[i_ra0[c_IW-1:0]] : '0;
  assign o_rd1 = (int'(i_ra1) < DEPTH) ? r_mem[i_ra1[c_IW-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/score_manager.sv
`default_nettype none
// ============================================================================
// Module      : score_manager
// Description : Needleman-Wunsch score matrix store. Initialises the gap
//               row/column, stores computed cell maxima and fetches the
//               diag/up/left neighbours of cell (i+1, j+1) over three
//               phases, pulsing ready once all three are captured.
//               Optional build macro SCORE_RANGE_CHECK_EN enables index
//               bound checks on init, insert and neighbour reads.
// Revision    : 1.0 - initial release
// ============================================================================
module score_manager
  import score_manager_pkg::*;
#(
  parameter int N           = 5,
  parameter int BitAddr     = $clog2(N),
  parameter int addr_lenght = $clog2((N + 1) * (N + 1) - 1)
) (
  input  logic            clk,
  input  logic            rst,
  score_manager_if.slave  bus
);

  localparam int c_DEPTH = (N + 1) * (N + 1);
  localparam int c_AW    = addr_lenght + 1;
  localparam int c_IDX_W = BitAddr + 1;

`ifdef SCORE_RANGE_CHECK_EN
  localparam bit c_RANGE_CHECK = 1'b1;
`else
  localparam bit c_RANGE_CHECK = 1'b0;
`endif

  // Mode decode
  logic w_act_init, w_act_ins, w_act_read;
  logic w_init_ok, w_ins_ok;

  // Integer views of the indices for address arithmetic
  int w_i, w_j, w_k, w_ri, w_rj;

  logic [c_AW-1:0]      w_cell_addr, w_diag_addr, w_up_addr, w_left_addr;
  logic                 w_diag_oob, w_up_oob, w_left_oob;

  logic                 w_we0, w_we1;
  logic [c_AW-1:0]      w_wa0, w_wa1;
  logic [c_SCORE_W-1:0] w_wd0, w_wd1, w_rd0, w_rd1, w_rd_q;

  phase_t               r_phase;
  logic                 r_vld;
  logic                 r_oob;
  logic                 r_ready;
  logic                 r_signal;
  logic [c_AW-1:0]      r_addr;
  logic [c_IDX_W-1:0]   r_i, r_j;
  logic [c_SCORE_W-1:0] r_diag, r_up, r_left, r_score;

  assign w_act_init = bus.en_init & bus.we;
  assign w_act_ins  = ~bus.en_init & bus.en_ins & bus.we;
  assign w_act_read = ~bus.en_init & ~bus.en_ins & bus.en_read;

  assign w_i  = int'(bus.i);
  assign w_j  = int'(bus.j);
  assign w_k  = int'(bus.addr_init);
  assign w_ri = int'(r_i);
  assign w_rj = int'(r_j);

  assign w_init_ok = !c_RANGE_CHECK || (w_k <= N);
  assign w_ins_ok  = !c_RANGE_CHECK || ((w_i < N) && (w_j < N));

  // Target cell of insertion and of the score output
  assign w_cell_addr = c_AW'(lin_addr(w_i + 1, w_j + 1, N));

  // Phase 0 uses live indices; phases 1/2 use the ones latched at phase 0
  assign w_diag_addr = c_AW'(lin_addr(w_i, w_j, N));
  assign w_up_addr   = c_AW'(lin_addr(w_ri, w_rj + 1, N));
  assign w_left_addr = c_AW'(lin_addr(w_ri + 1, w_rj, N));

  assign w_diag_oob = c_RANGE_CHECK && ((w_i > N) || (w_j > N));
  assign w_up_oob   = c_RANGE_CHECK && ((w_ri > N) || (w_rj + 1 > N));
  assign w_left_oob = c_RANGE_CHECK && ((w_ri + 1 > N) || (w_rj > N));

  // Init writes (0,k) on port 0 and (k,0) on port 1; insert uses port 0
  assign w_we0 = (w_act_init & w_init_ok) | (w_act_ins & w_ins_ok);
  assign w_wa0 = w_act_init ? c_AW'(lin_addr(0, w_k, N)) : w_cell_addr;
  assign w_wd0 = w_act_init ? bus.data_init : bus.max;
  assign w_we1 = w_act_init & w_init_ok;
  assign w_wa1 = c_AW'(lin_addr(w_k, 0, N));
  assign w_wd1 = bus.data_init;

  score_ram #(
    .DEPTH (c_DEPTH),
    .AW    (c_AW),
    .DW    (c_SCORE_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .i_we0 (w_we0),
    .i_wa0 (w_wa0),
    .i_wd0 (w_wd0),
    .i_we1 (w_we1),
    .i_wa1 (w_wa1),
    .i_wd1 (w_wd1),
    .i_ra0 (r_addr),
    .o_rd0 (w_rd0),
    .i_ra1 (w_cell_addr),
    .o_rd1 (w_rd1)
  );

  // An out-of-range neighbour captures as zero
  assign w_rd_q = r_oob ? '0 : w_rd0;

  // Neighbour fetch FSM: issue an address, capture its data next edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= DIAG;
      r_vld   <= 1'b0;
      r_oob   <= 1'b0;
      r_addr  <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_diag  <= '0;
      r_up    <= '0;
      r_left  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (!w_act_read) begin
        r_phase <= DIAG;
        r_vld   <= 1'b0;
      end else if (!r_vld) begin
        r_addr  <= w_diag_addr;
        r_oob   <= w_diag_oob;
        r_i     <= bus.i;
        r_j     <= bus.j;
        r_phase <= DIAG;
        r_vld   <= 1'b1;
      end else begin
        case (r_phase)
          DIAG: begin
            r_diag  <= w_rd_q;
            r_addr  <= w_up_addr;
            r_oob   <= w_up_oob;
            r_phase <= UP;
          end
          UP: begin
            r_up    <= w_rd_q;
            r_addr  <= w_left_addr;
            r_oob   <= w_left_oob;
            r_phase <= LEFT;
          end
          LEFT: begin
            r_left  <= w_rd_q;
            r_ready <= 1'b1;
            r_addr  <= w_diag_addr;
            r_oob   <= w_diag_oob;
            r_i     <= bus.i;
            r_j     <= bus.j;
            r_phase <= DIAG;
          end
          default: begin
            r_phase <= DIAG;
            r_vld   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Insert acknowledge and continuous readback of cell (i+1, j+1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_signal <= 1'b0;
      r_score  <= '0;
    end else begin
      r_signal <= w_act_ins & w_ins_ok;
      r_score  <= w_rd1;
    end
  end

  assign bus.count_3 = r_phase;
  assign bus.addr_r  = r_addr;
  assign bus.diag    = r_diag;
  assign bus.up      = r_up;
  assign bus.left    = r_left;
  assign bus.score   = r_score;
  assign bus.ready   = r_ready;
  assign bus.signal  = r_signal;

endmodule
`default_nettype wire

// File: tb/tb_score_manager.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_score_manager
// Description : Self-checking bench for score_manager: border init, cell
//               insertion, table-driven neighbour fetches with a queue of
//               expected neighbour triples, mode priority and mid-fetch reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_manager;
  import score_manager_pkg::*;

  localparam int c_N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  score_manager_if #(.N(c_N)) bus ();

  score_manager #(.N(c_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct { int k; int d; } init_vec_t;
  typedef struct { int i; int j; int m; } ins_vec_t;
  typedef struct { int i; int j; int d; int u; int l; } rd_vec_t;
  typedef struct { int d; int u; int l; } nb_t;

  nb_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_modes();
    bus.en_init = 1'b0;
    bus.en_ins  = 1'b0;
    bus.en_read = 1'b0;
    bus.we      = 1'b0;
  endtask

  // Pop the oldest expected triple and compare with captured neighbours
  task automatic pop_compare(input string tag);
    nb_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " unexpected ready"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " diag"}, int'(bus.diag), e.d);
      chk({tag, " up"},   int'(bus.up),   e.u);
      chk({tag, " left"}, int'(bus.left), e.l);
    end
  endtask

  // One full neighbour fetch; ready is expected after the 4th edge
  task automatic fetch(input rd_vec_t v, input string tag);
    nb_t e;
    int  got;
    e.d = v.d; e.u = v.u; e.l = v.l;
    exp_q.push_back(e);
    bus.i = v.i[3:0];
    bus.j = v.j[3:0];
    bus.en_read = 1'b1;
    got = 0;
    for (int c = 1; c <= 8 && got == 0; c++) begin
      tick();
      if (c <= 3) chk({tag, " count_3"}, int'(bus.count_3), c - 1);
      if (bus.ready) got = c;
    end
    if (got == 0) begin
      chk({tag, " ready timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end else begin
      chk({tag, " ready latency"}, got, 4);
      pop_compare(tag);
    end
    bus.en_read = 1'b0;
    tick();
    chk({tag, " ready single pulse"}, int'(bus.ready), 0);
  endtask

  init_vec_t init_tab[3];
  ins_vec_t  ins_tab[4];
  rd_vec_t   rd_tab[4];

  initial begin : main
    rd_vec_t v;
    int      rdy_at[2];
    int      n_rdy;
    bit      saw_ready;

    init_tab = '{'{0, 0}, '{1, 16}, '{2, 12}};
    ins_tab  = '{'{0, 0, 7}, '{1, 0, 13}, '{0, 1, 8}, '{1, 1, 14}};
    rd_tab   = '{'{0, 0, 0, 16, 16}, '{0, 1, 16, 12, 7},
                 '{1, 0, 16, 7, 12},  '{1, 1, 7, 8, 13}};

    clear_modes();
    bus.i = '0; bus.j = '0; bus.addr_init = '0;
    bus.max = '0; bus.data_init = '0;

    // Reset
    rst = 1'b0;
    repeat (8) tick();
    chk("reset diag",    int'(bus.diag),    0);
    chk("reset up",      int'(bus.up),      0);
    chk("reset left",    int'(bus.left),    0);
    chk("reset score",   int'(bus.score),   0);
    chk("reset ready",   int'(bus.ready),   0);
    chk("reset signal",  int'(bus.signal),  0);
    chk("reset count_3", int'(bus.count_3), 0);
    chk("reset addr_r",  int'(bus.addr_r),  0);
    rst = 1'b1;
    tick();

    // Border initialisation
    foreach (init_tab[n]) begin
      bus.en_init = 1'b1; bus.we = 1'b1;
      bus.addr_init = init_tab[n].k[3:0];
      bus.data_init = init_tab[n].d[8:0];
      tick();
      clear_modes();
    end

    // Cell insertion: signal pulses exactly once per write
    foreach (ins_tab[n]) begin
      bus.en_ins = 1'b1; bus.we = 1'b1;
      bus.i = ins_tab[n].i[3:0];
      bus.j = ins_tab[n].j[3:0];
      bus.max = ins_tab[n].m[8:0];
      tick();
      chk("insert signal pulse", int'(bus.signal), 1);
      clear_modes();
      tick();
      chk("insert signal low", int'(bus.signal), 0);
    end

    bus.i = 4'd1; bus.j = 4'd1;
    tick();
    chk("score cell(2,2)", int'(bus.score), 14);

    // Table-driven neighbour fetches
    foreach (rd_tab[n]) fetch(rd_tab[n], $sformatf("read(%0d,%0d)", rd_tab[n].i, rd_tab[n].j));

    // Back-to-back fetch: indices change after phase 0, period is 3
    v = '{0, 0, 0, 16, 16};
    exp_q.push_back('{v.d, v.u, v.l});
    exp_q.push_back('{7, 8, 13});
    bus.i = 4'd0; bus.j = 4'd0; bus.en_read = 1'b1;
    tick();
    bus.i = 4'd1; bus.j = 4'd1;
    n_rdy = 0;
    for (int c = 2; c <= 12 && n_rdy < 2; c++) begin
      tick();
      if (bus.ready) begin
        rdy_at[n_rdy] = c;
        n_rdy++;
        pop_compare("b2b");
      end
    end
    bus.en_read = 1'b0;
    chk("b2b ready count", n_rdy, 2);
    if (n_rdy == 2) begin
      chk("b2b first ready", rdy_at[0], 4);
      chk("b2b period", rdy_at[1] - rdy_at[0], 3);
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    tick();

    // Priority: init and insert together -> only init acts
    bus.en_init = 1'b1; bus.en_ins = 1'b1; bus.we = 1'b1;
    bus.addr_init = 4'd3; bus.data_init = 9'd21;
    bus.i = 4'd0; bus.j = 4'd0; bus.max = 9'd99;
    tick();
    chk("priority signal", int'(bus.signal), 0);
    clear_modes();
    tick();
    chk("priority score(1,1)", int'(bus.score), 7);
    fetch('{0, 2, 12, 21, 8}, "read(0,2)");

    // Insert without we is ignored
    bus.en_ins = 1'b1; bus.we = 1'b0;
    bus.i = 4'd0; bus.j = 4'd0; bus.max = 9'd55;
    tick();
    chk("no-we signal", int'(bus.signal), 0);
    clear_modes();
    tick();
    chk("no-we score(1,1)", int'(bus.score), 7);

    // Reset in the middle of a fetch
    bus.i = 4'd1; bus.j = 4'd1; bus.en_read = 1'b1;
    tick();
    tick();
    chk("midreset phase before", int'(bus.count_3), 1);
    rst = 1'b0;
    #1;
    chk("midreset count_3", int'(bus.count_3), 0);
    chk("midreset diag", int'(bus.diag), 0);
    tick();
    rst = 1'b1;
    bus.en_read = 1'b0;
    saw_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.ready) saw_ready = 1'b1;
    end
    chk("midreset no ready", int'(saw_ready), 0);
    chk("midreset cells cleared", int'(bus.score), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
